// File: rtl/hailstone_engine.sv
// Hailstone (Collatz) sequence engine: emits one term per cycle from n_in down to 1.
// Optional macro HAILSTONE_PEAK_EN builds the peak-term tracker; otherwise peak is tied to 0.
module hailstone_engine #(
    parameter int WIDTH      = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      n_in,
    output logic                  busy,
    output logic                  value_valid,
    output logic [WIDTH-1:0]      value_out,
    output logic                  done,
    output logic [STEP_WIDTH-1:0] steps,
    output logic [WIDTH-1:0]      peak,
    output logic                  overflow,
    output logic                  error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_cur;
    logic [WIDTH-1:0]      w_cur_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [STEP_WIDTH-1:0] r_steps;
    logic [STEP_WIDTH-1:0] w_steps_nxt;
    logic                  r_ovf;
    logic                  w_ovf_nxt;
    logic                  r_err;
    logic                  w_err_nxt;

    logic [WIDTH+1:0]      w_triple;
    logic                  w_tri_ovf;
    logic                  w_steps_max;
    logic                  w_is_one;
    logic                  w_n_zero;
    logic [STEP_WIDTH-1:0] w_steps_inc;

    // 3*cur+1 carried two bits wider so the overflow check sees the true result
    assign w_triple    = ({2'b00, r_cur} << 1) + {2'b00, r_cur} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_tri_ovf   = |w_triple[WIDTH+1:WIDTH];
    assign w_steps_max = (r_steps == {STEP_WIDTH{1'b1}});
    assign w_is_one    = (r_cur == {{(WIDTH-1){1'b0}}, 1'b1});
    assign w_n_zero    = (n_in == {WIDTH{1'b0}});
    assign w_steps_inc = r_steps + {{(STEP_WIDTH-1){1'b0}}, 1'b1};

    // Next-state and next-output decode for the IDLE/RUN/DONE sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_steps_nxt = r_steps;
        w_ovf_nxt   = r_ovf;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt  = 1'b1;
                    w_steps_nxt = {STEP_WIDTH{1'b0}};
                    w_ovf_nxt   = 1'b0;
                    if (w_n_zero) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cur_nxt   = n_in;
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_busy_nxt = 1'b1;
                if (w_is_one) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (w_steps_max) begin
                    // steps saturate rather than wrap: stop with overflow
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else if (!r_cur[0]) begin
                    w_cur_nxt   = r_cur >> 1;
                    w_steps_nxt = w_steps_inc;
                    w_valid_nxt = 1'b1;
                end else if (w_tri_ovf) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_cur_nxt   = w_triple[WIDTH-1:0];
                    w_steps_nxt = w_steps_inc;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cur   <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_steps <= {STEP_WIDTH{1'b0}};
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_steps <= w_steps_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef HAILSTONE_PEAK_EN
    logic [WIDTH-1:0] r_peak;
    logic             w_peak_load;
    logic             w_peak_upd;

    // Halving never raises the peak, so only successful odd steps are compared
    assign w_peak_load = (r_state == ST_IDLE) && start && !w_n_zero;
    assign w_peak_upd  = (r_state == ST_RUN) && !w_is_one && !w_steps_max && r_cur[0]
                         && !w_tri_ovf && (w_triple[WIDTH-1:0] > r_peak);

    // Peak register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak <= {WIDTH{1'b0}};
        end else if (w_peak_load) begin
            r_peak <= n_in;
        end else if (w_peak_upd) begin
            r_peak <= w_triple[WIDTH-1:0];
        end else begin
            r_peak <= r_peak;
        end
    end

    assign peak = r_peak;
`else
    assign peak = {WIDTH{1'b0}};
`endif

    assign busy        = r_busy;
    assign value_valid = r_valid;
    assign value_out   = r_cur;
    assign done        = r_done;
    assign steps       = r_steps;
    assign overflow    = r_ovf;
    assign error       = r_err;

endmodule
